// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one uart_tx serializer from NUM_REQ byte producers.
// Optional packet lock (UART_ARB_LOCK_EN) keeps the line with one requester.
module uart_tx_arbiter #(
   parameter  int NUM_REQ    = 4,
   parameter  int GAP_CYCLES = 87,
   localparam int IDW        = $clog2(NUM_REQ)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NUM_REQ-1:0]   i_req,
   input  logic [8*NUM_REQ-1:0] i_byte,
   output logic [NUM_REQ-1:0]   o_ack,
   output logic [NUM_REQ-1:0]   o_done,
   output logic                 o_Tx_Dv,
   output logic [7:0]           o_Tx_Byte,
   input  logic                 i_Tx_Active,
   input  logic                 i_Tx_Done,
`ifdef UART_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]   i_lock,
`endif
   output logic                 o_busy,
   output logic [IDW-1:0]       o_grant_id
);

   localparam int CW     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int GAP_LD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t               state_q, state_d;
   logic [IDW-1:0]       rr_q, rr_d;
   logic [IDW-1:0]       gid_q, gid_d;
   logic [7:0]           byte_q, byte_d;
   logic                 dv_q, dv_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   elig;
   logic                 found;
   logic [IDW-1:0]       sel;
   logic [IDW-1:0]       rr_nxt;
   logic                 keep_lock;
`ifdef UART_ARB_LOCK_EN
   logic                 lk_q, lk_d;
   logic [IDW-1:0]       lkid_q, lkid_d;
`endif

   // A held lock narrows the eligible set to the owner only.
   always_comb begin
      elig      = i_req;
      keep_lock = 1'b0;
`ifdef UART_ARB_LOCK_EN
      if (lk_q && i_lock[lkid_q])
         elig = i_req & (NUM_REQ'(1) << lkid_q);
      keep_lock = i_lock[gid_q];
`endif
   end

   always_comb begin
      int j;
      found = 1'b0;
      sel   = '0;
      j     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(rr_q) + i;
         if (j >= NUM_REQ)
            j = j - NUM_REQ;
         if (!found && elig[IDW'(j)]) begin
            found = 1'b1;
            sel   = IDW'(j);
         end
      end
   end

   assign rr_nxt = (gid_q == IDW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gid_d   = gid_q;
      byte_d  = byte_q;
      dv_d    = 1'b0;
      ack_d   = '0;
      done_d  = '0;
      cnt_d   = cnt_q;
`ifdef UART_ARB_LOCK_EN
      lk_d    = lk_q;
      lkid_d  = lkid_q;
`endif
      unique case (state_q)
         IDLE: begin
`ifdef UART_ARB_LOCK_EN
            if (lk_q && !i_lock[lkid_q])
               lk_d = 1'b0;
`endif
            if (found && !i_Tx_Active) begin
               dv_d       = 1'b1;
               ack_d[sel] = 1'b1;
               gid_d      = sel;
               byte_d     = i_byte[8*sel +: 8];
               state_d    = SEND;
            end
         end
         SEND: begin
            if (i_Tx_Done) begin
               done_d[gid_q] = 1'b1;
               if (!keep_lock)
                  rr_d = rr_nxt;
`ifdef UART_ARB_LOCK_EN
               lk_d   = keep_lock;
               lkid_d = gid_q;
`endif
               cnt_d   = CW'(GAP_LD);
               state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (cnt_q == '0)
               state_d = IDLE;
            else
               cnt_d = cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         gid_q   <= '0;
         byte_q  <= 8'h00;
         dv_q    <= 1'b0;
         ack_q   <= '0;
         done_q  <= '0;
         cnt_q   <= '0;
`ifdef UART_ARB_LOCK_EN
         lk_q    <= 1'b0;
         lkid_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gid_q   <= gid_d;
         byte_q  <= byte_d;
         dv_q    <= dv_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
`ifdef UART_ARB_LOCK_EN
         lk_q    <= lk_d;
         lkid_q  <= lkid_d;
`endif
      end
   end

   assign o_ack      = ack_q;
   assign o_done     = done_q;
   assign o_Tx_Dv    = dv_q;
   assign o_Tx_Byte  = byte_q;
   assign o_busy     = (state_q != IDLE);
   assign o_grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: dut0 has no gap, dut1 has an 87-cycle gap.
// Lock sequence is exercised when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] bytes = '0;
   logic        act = 1'b0;
   logic        done = 1'b0;
   logic [3:0]  lock_v = '0;

   logic [3:0] ack0, done0, ack1, done1;
   logic       dv0, dv1, busy0, busy1;
   logic [7:0] tb0, tb1;
   logic [1:0] id0, id1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_byte(bytes),
      .o_ack(ack0), .o_done(done0), .o_Tx_Dv(dv0), .o_Tx_Byte(tb0),
      .i_Tx_Active(act), .i_Tx_Done(done),
`ifdef UART_ARB_LOCK_EN
      .i_lock(lock_v),
`endif
      .o_busy(busy0), .o_grant_id(id0));

   uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(87)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_byte(bytes),
      .o_ack(ack1), .o_done(done1), .o_Tx_Dv(dv1), .o_Tx_Byte(tb1),
      .i_Tx_Active(act), .i_Tx_Done(done),
`ifdef UART_ARB_LOCK_EN
      .i_lock(lock_v),
`endif
      .o_busy(busy1), .o_grant_id(id1));

   typedef struct {
      logic [3:0]  req;
      logic [31:0] bytes;
      logic [3:0]  ack;
      logic [1:0]  id;
      logic [7:0]  b;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic grant(input vec_t v, input logic [3:0] req_after,
                        input logic [3:0] lk_done, input string tag);
      req   = v.req;
      bytes = v.bytes;
      step();
      chk({tag, " ack"}, 32'(ack0), 32'(v.ack));
      chk({tag, " dv"}, 32'(dv0), 32'd1);
      chk({tag, " byte"}, 32'(tb0), 32'(v.b));
      chk({tag, " id"}, 32'(id0), 32'(v.id));
      chk({tag, " busy"}, 32'(busy0), 32'd1);
      req = req_after;
      step();
      chk({tag, " dv1cyc"}, 32'(dv0), 32'd0);
      done   = 1'b1;
      lock_v = lk_done;
      step();
      done = 1'b0;
      chk({tag, " done"}, 32'(done0), 32'(v.ack));
      chk({tag, " hold"}, 32'(tb0), 32'(v.b));
      chk({tag, " ackclr"}, 32'(ack0), 32'd0);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      int early;
      tbl[0] = '{4'b1111, 32'hA3A2A1A0, 4'b0001, 2'd0, 8'hA0};
      tbl[1] = '{4'b1111, 32'hA3A2A1A0, 4'b0010, 2'd1, 8'hA1};
      tbl[2] = '{4'b1111, 32'hA3A2A1A0, 4'b0100, 2'd2, 8'hA2};
      tbl[3] = '{4'b1111, 32'hA3A2A1A0, 4'b1000, 2'd3, 8'hA3};
      tbl[4] = '{4'b1111, 32'hA3A2A1A0, 4'b0001, 2'd0, 8'hA0};
      tbl[5] = '{4'b0101, 32'h44332211, 4'b0100, 2'd2, 8'h33};
      tbl[6] = '{4'b0011, 32'h44332211, 4'b0001, 2'd0, 8'h11};
      tbl[7] = '{4'b1000, 32'h44332211, 4'b1000, 2'd3, 8'h44};

      #1 rst = 1'b1;
      step();
      step();
      chk("rst ack", 32'(ack0), 32'd0);
      chk("rst done", 32'(done0), 32'd0);
      chk("rst dv", 32'(dv0), 32'd0);
      chk("rst byte", 32'(tb0), 32'd0);
      chk("rst busy", 32'(busy0), 32'd0);
      chk("rst id", 32'(id0), 32'd0);
      chk("rst busy1", 32'(busy1), 32'd0);
      chk("rst dv1", 32'(dv1), 32'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 8; i++)
         grant(tbl[i], tbl[i].req, 4'b0000, $sformatf("vec%0d", i));
      req = '0;
      step();
      chk("idle busy", 32'(busy0), 32'd0);
      chk("idle ack", 32'(ack0), 32'd0);

      // transmitter owned externally: no grant while active
      act   = 1'b1;
      req   = 4'b0100;
      bytes = 32'h00C20000;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("extbusy noack", 32'(ack0), 32'd0);
      end
      act = 1'b0;
      step();
      chk("extbusy ack", 32'(ack0), 32'b0100);
      chk("extbusy byte", 32'(tb0), 32'hC2);
      req = '0;
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      chk("extbusy done", 32'(done0), 32'b0100);

      done = 1'b1;
      step();
      done = 1'b0;
      chk("stray done", 32'(done0), 32'd0);
      chk("stray busy", 32'(busy0), 32'd0);

      // reset in SEND; rr_ptr was 3 before the abort
      req   = 4'b1000;
      bytes = 32'hD3000000;
      step();
      chk("mid ack", 32'(ack0), 32'b1000);
      req = '0;
      step();
      rst = 1'b1;
      #1;
      chk("mid rst ack", 32'(ack0), 32'd0);
      chk("mid rst busy", 32'(busy0), 32'd0);
      chk("mid rst byte", 32'(tb0), 32'd0);
      chk("mid rst id", 32'(id0), 32'd0);
      #2 rst = 1'b0;
      grant('{4'b1001, 32'hD30000D0, 4'b0001, 2'd0, 8'hD0}, 4'b1000, 4'b0000, "post0");
      grant('{4'b1000, 32'hD30000D0, 4'b1000, 2'd3, 8'hD3}, 4'b0000, 4'b0000, "post3");

      // inter-frame gap on dut1
      reset_pulse();
      req   = 4'b0100;
      bytes = 32'h005A0000;
      step();
      chk("gap ack", 32'(ack1), 32'b0100);
      chk("gap byte", 32'(tb1), 32'h5A);
      bytes = 32'h005B0000;
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      chk("gap done", 32'(done1), 32'b0100);
      chk("gap busy", 32'(busy1), 32'd1);
      n     = 0;
      early = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         n++;
         if (dv1)
            break;
         if (ack1 != 4'b0000)
            early++;
      end
      chk("gap dist", 32'(n), 32'd88);
      chk("gap early", 32'(early), 32'd0);
      chk("gap byte2", 32'(tb1), 32'h5B);
      chk("gap ack2", 32'(ack1), 32'b0100);
      req = '0;
      step();
      done = 1'b1;
      step();
      done = 1'b0;
      chk("gap done2", 32'(done1), 32'b0100);

`ifdef UART_ARB_LOCK_EN
      reset_pulse();
      lock_v = 4'b0010;
      grant('{4'b0010, 32'h0000B1C0, 4'b0010, 2'd1, 8'hB1}, 4'b0011, 4'b0010, "lock1");
      grant('{4'b0011, 32'h0000B1C0, 4'b0010, 2'd1, 8'hB1}, 4'b0011, 4'b0010, "lock2");
      grant('{4'b0011, 32'h0000B1C0, 4'b0010, 2'd1, 8'hB1}, 4'b0001, 4'b0000, "lock3");
      grant('{4'b0001, 32'h0000B1C0, 4'b0001, 2'd0, 8'hC0}, 4'b0000, 4'b0000, "unlock");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter sharing one `uart_tx` serializer (8 data bits, even parity, 1 stop bit, `CLK_CY_PER_BIT` clocks per bit) among `NUM_REQ` byte producers. It captures one byte from the winning requester and launches it with a one-cycle `o_Tx_Dv` pulse. It then waits for the transmitter's `i_Tx_Done`, enforces an optional inter-frame idle gap, and reports per-requester completion. It sits between the system-side producers and the single UART TX line driver.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `GAP_CYCLES`, 87: extra idle clocks after each `i_Tx_Done` before the next grant; 0 disables the gap.
- `IDW`, `$clog2(NUM_REQ)`: grant index width; derived, not overridden.

Ports (clock and reset first):
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_req`  in  `NUM_REQ`  level request, one bit per requester.
- `i_byte`  in  `8*NUM_REQ`  packed bytes; requester k occupies bits [8k+7:8k].
- `o_ack`  out  `NUM_REQ`  one-cycle pulse: the byte of requester k has been captured.
- `o_done`  out  `NUM_REQ`  one-cycle pulse: the byte of requester k has finished on the line.
- `o_Tx_Dv`  out  1  one-cycle start strobe to `uart_tx`.
- `o_Tx_Byte`  out  8  byte to `uart_tx`; held stable from the strobe until done.
- `i_Tx_Active`  in  1  `uart_tx` is busy.
- `i_Tx_Done`  in  1  `uart_tx` end-of-frame pulse.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_grant_id`  out  `IDW`  index of the current or most recent grantee.
- `i_lock`  in  `NUM_REQ`  present only when `UART_ARB_LOCK_EN` is defined (see Configuration).

## Operation
- States: IDLE, SEND, GAP.
- IDLE, when `i_req` is non-zero and `i_Tx_Active` is 0:
  - Select the first set bit at or above `rr_ptr`, wrapping from `NUM_REQ-1` to 0.
  - On the next edge: register `o_Tx_Byte` from that requester's `i_byte` slice, pulse `o_Tx_Dv` and `o_ack[k]`, set `o_grant_id` to k, and go to SEND.
- IDLE with `i_Tx_Active` = 1: no grant. The transmitter is owned externally, so stay in IDLE.
- SEND: wait for `i_Tx_Done`. Then pulse `o_done[grant_id]` on the next cycle and set `rr_ptr` to `grant_id+1` (mod `NUM_REQ`).
  - Go to GAP when `GAP_CYCLES` > 0; otherwise go to IDLE.
  - `i_req` is ignored in SEND; requests are sampled only in IDLE.
- GAP: counter loads `GAP_CYCLES-1` and decrements to 0, then go to IDLE. Counter width is `$clog2(GAP_CYCLES+1)`.
- Requester protocol:
  - Hold `i_req` and `i_byte` stable until `o_ack` is seen.
  - Deassert `i_req`, or present the next byte, in the cycle after `o_ack`.
  - A request still high in IDLE is treated as a new byte.
- Simultaneous requests: exactly one `o_ack` bit is set per grant.
- `i_Tx_Done` outside SEND is ignored.
- `i_rst` asserted mid-frame aborts immediately: all outputs and state return to reset values. The `uart_tx` instance is reset separately.

## Timing
- Reset values:
  - state = IDLE, `rr_ptr` = 0, `o_grant_id` = 0.
  - `o_Tx_Byte` = 8'h00; `o_Tx_Dv`, `o_ack`, `o_done`, `o_busy` = 0.
- Grant latency: request visible in IDLE at edge N gives `o_Tx_Dv` and `o_ack` high for the cycle after edge N, and `o_busy` high from edge N.
- `o_done` is high for the one cycle after the edge that samples `i_Tx_Done`.
- Next grant earliest:
  - `GAP_CYCLES` = 0: one cycle after `o_done`.
  - Otherwise: `GAP_CYCLES` cycles after GAP is entered.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `UART_ARB_LOCK_EN` defined: `i_lock` port exists. When requester k's `i_lock` bit is high at its `i_Tx_Done`:
  - k becomes lock owner and `rr_ptr` is not advanced.
  - In IDLE only k may be granted; other requests wait.
  - The lock is released when k's `i_lock` is low at done, or when it is low while in IDLE.
  - This allows contiguous multi-byte packets.
- `UART_ARB_LOCK_EN` undefined: `i_lock` port is absent and arbitration is pure round-robin.

## Test plan
- Single request: `i_req`=4'b0001, byte 8'h8B, `GAP_CYCLES`=0, real `uart_tx`/`uart_rx` loopback at 87 clk/bit → `o_ack[0]` pulse 1 cycle after request; the receiver outputs 8'h8B with parity 0; `o_done[0]` pulse.
- Contention: `i_req`=4'b1111 held, bytes 8'hA0..8'hA3 → grant order 0,1,2,3,0; each `o_ack` one-hot.
- Gap: `GAP_CYCLES`=87, two back-to-back requests from requester 2 → second `o_Tx_Dv` exactly 88 cycles after the first `o_done`.
- External busy: `i_Tx_Active`=1 with `i_req`=4'b0100 → no `o_ack` until `i_Tx_Active` falls, then grant on the next edge.
- Reset mid-frame: assert `i_rst` during SEND → next cycle state IDLE, all outputs 0, `rr_ptr`=0; the following request from requester 3 is granted normally.
- Lock (`UART_ARB_LOCK_EN`): requester 1 sends 3 bytes with `i_lock[1]`=1 while requester 0 also requests → grants 1,1,1; drop lock → grant 0.
